bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 132 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble)
//   method, one shift per clock. A conversion of a W-bit value takes W cycles
//   in SHIFT followed by a single DONE cycle. Values above 9999 saturate the
//   displayed digits to 9999 and raise oOVF.
//
// Ports
//   iCLK    system clock, rising edge
//   iRST    synchronous active-high reset
//   iSTART  conversion request, sampled only while idle
//   iBIN    unsigned binary value, captured on the accepting edge only
//   oBUSY   high in SHIFT and DONE
//   oDONE   one-cycle pulse, result valid
//   oOVF    last converted value exceeded 9999
//   oD0..3  BCD digits, units .. thousands; held until the next DONE or reset
module bin_to_bcd_seq #(
    parameter int W = 14
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         iSTART,
    input  logic [W-1:0] iBIN,
    output logic         oBUSY,
    output logic         oDONE,
    output logic         oOVF,
    output logic [3:0]   oD0,
    output logic [3:0]   oD1,
    output logic [3:0]   oD2,
    output logic [3:0]   oD3
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0] bin_sr;
    logic [15:0]  scratch;
    logic [4:0]   cnt;
    logic         ovf;

    logic [15:0]  adj;
    logic [15:0]  scratch_shift;
    logic [W-1:0] bin_shift;
    logic [16:0]  bin_wide;
    logic         last_shift;

    assign bin_wide   = 17'(iBIN);
    assign last_shift = (state == SHIFT) && (cnt == 5'd1);

    // One double-dabble step: add 3 to every digit >= 5, then shift the
    // combined {scratch, binary} register left by one. Digits may wrap when
    // the input exceeds 9999; that result is discarded by the saturation path.
    always_comb begin
        adj = scratch;
        for (int unsigned i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        {scratch_shift, bin_shift} = {adj, bin_sr} << 1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (iSTART) state_next = SHIFT;
            SHIFT:   if (cnt == 5'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            oBUSY   <= 1'b0;
            oDONE   <= 1'b0;
            oOVF    <= 1'b0;
            oD0     <= '0;
            oD1     <= '0;
            oD2     <= '0;
            oD3     <= '0;
        end else begin
            oBUSY <= (state_next != IDLE);
            oDONE <= (state_next == DONE);

            if (state == IDLE && iSTART) begin
                bin_sr  <= iBIN;
                scratch <= '0;
                cnt     <= 5'(W);
                ovf     <= (bin_wide > 17'd9999);
            end else if (state == SHIFT) begin
                bin_sr  <= bin_shift;
                scratch <= scratch_shift;
                cnt     <= cnt - 5'd1;
            end

            // Results are taken from the shifted value of the final step so
            // they appear together with the DONE pulse.
            if (last_shift) begin
                if (ovf) begin
                    oOVF <= 1'b1;
                    oD3  <= 4'd9;
                    oD2  <= 4'd9;
                    oD1  <= 4'd9;
                    oD0  <= 4'd9;
                end else begin
                    oOVF <= 1'b0;
                    oD3  <= scratch_shift[15:12];
                    oD2  <= scratch_shift[11:8];
                    oD1  <= scratch_shift[7:4];
                    oD0  <= scratch_shift[3:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
//   Self-checking bench for bin_to_bcd_seq (W = 14). Expected results come
//   from a decimal reference model using division and modulo.
module tb_bin_to_bcd_seq;

    localparam int W = 14;

    logic         iCLK;
    logic         iRST;
    logic         iSTART;
    logic [W-1:0] iBIN;
    logic         oBUSY;
    logic         oDONE;
    logic         oOVF;
    logic [3:0]   oD0;
    logic [3:0]   oD1;
    logic [3:0]   oD2;
    logic [3:0]   oD3;

    int n_vec = 0;
    int n_err = 0;

    bin_to_bcd_seq #(.W(W)) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iSTART (iSTART),
        .iBIN   (iBIN),
        .oBUSY  (oBUSY),
        .oDONE  (oDONE),
        .oOVF   (oOVF),
        .oD0    (oD0),
        .oD1    (oD1),
        .oD2    (oD2),
        .oD3    (oD3)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, d3, d2, d1, d0}
    function automatic logic [16:0] ref_model(input int unsigned v);
        if (v > 9999)
            return {1'b1, 16'h9999};
        return {1'b0, 4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [16:0] result();
        return {oOVF, oD3, oD2, oD1, oD0};
    endfunction

    // Wait (bounded) for oDONE, sampling on falling edges. Optionally checks
    // oBUSY every cycle and disturbs iSTART/iBIN while the conversion runs.
    task automatic wait_done(input string tag, input bit chk_busy, input bit wiggle, output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge iCLK);
            cyc++;
            if (oDONE || cyc >= 60) break;
            if (chk_busy) check({tag, "/busy"}, 32'(oBUSY), 32'd1);
            if (wiggle) begin
                iSTART = 1'($urandom % 2);
                iBIN   = 14'd1111;
            end
        end
        iSTART = 1'b0;
    endtask

    task automatic run_conv(input logic [W-1:0] v, input bit wiggle, input string tag);
        int cyc;
        @(negedge iCLK);
        iRST   = 1'b0;
        iBIN   = v;
        iSTART = 1'b1;
        @(posedge iCLK);
        #1;
        iSTART = 1'b0;
        iBIN   = W'($urandom);
        wait_done(tag, 1'b1, wiggle, cyc);
        check({tag, "/lat"}, 32'(cyc), 32'(W + 1));
        check({tag, "/res"}, 32'(result()), 32'(ref_model(32'(v))));
        @(negedge iCLK);
        check({tag, "/after"}, {30'd0, oBUSY, oDONE}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [W-1:0] bounds [12];
        bounds = '{14'd0, 14'd1, 14'd9, 14'd10, 14'd99, 14'd100, 14'd999,
                   14'd1000, 14'd9998, 14'd9999, 14'd10000, 14'd16383};

        // Reset dominates a pending start.
        iRST   = 1'b1;
        iSTART = 1'b1;
        iBIN   = 14'd777;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        check("reset", {15'd0, oBUSY, oDONE, result()}, 32'd0);

        // First edge with reset low and start high is accepted.
        run_conv(14'd1234, 1'b0, "c1234");

        // Back-to-back with start held high.
        @(negedge iCLK);
        iBIN   = 14'd0;
        iSTART = 1'b1;
        @(posedge iCLK);
        #1 iBIN = 14'd9999;
        cyc = 0;
        while (1) begin
            @(negedge iCLK);
            cyc++;
            if (oDONE || cyc >= 60) break;
        end
        check("b2b0/lat", 32'(cyc), 32'(W + 1));
        check("b2b0/res", 32'(result()), 32'(ref_model(0)));
        cyc = 0;
        while (1) begin
            @(negedge iCLK);
            cyc++;
            if (oDONE || cyc >= 60) break;
        end
        iSTART = 1'b0;
        check("b2b1/gap", 32'(cyc), 32'(W + 2));
        check("b2b1/res", 32'(result()), 32'(ref_model(9999)));
        repeat (3) begin
            @(negedge iCLK);
            check("b2b/idle", {30'd0, oBUSY, oDONE}, 32'd0);
        end

        // Overflow saturation, then cleared by an in-range value.
        run_conv(14'd10000, 1'b0, "ovf10000");
        run_conv(14'd16383, 1'b0, "ovf16383");
        run_conv(14'd42,    1'b0, "c0042");

        // Start toggling and input changes during SHIFT are ignored.
        run_conv(14'd5678, 1'b1, "c5678w");

        // Reset in the 7th SHIFT cycle aborts the conversion.
        @(negedge iCLK);
        iBIN   = 14'd4321;
        iSTART = 1'b1;
        @(posedge iCLK);
        #1 iSTART = 1'b0;
        repeat (7) @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        check("abort/out", {15'd0, oBUSY, oDONE, result()}, 32'd0);
        cyc = 0;
        repeat (20) begin
            @(negedge iCLK);
            if (oDONE || oBUSY) cyc++;
        end
        check("abort/quiet", 32'(cyc), 32'd0);
        run_conv(14'd4321, 1'b0, "c4321");

        // Boundary values and random sample against the reference model.
        foreach (bounds[i]) run_conv(bounds[i], 1'b0, "bound");
        repeat (200) run_conv(W'($urandom_range(0, 16383)), 1'($urandom % 2), "rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
